// File: rtl/mod_mult_interleaved.sv
// Radix-2, MSB-first interleaved modular multiplier: product = (a * b) mod p in WIDTH+1 cycles.
// Define MODMUL_ABORT_EN to add an abort input that cancels a running multiplication.
module mod_mult_interleaved #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             Reset,
`ifdef MODMUL_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] p,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_r;
   logic [WIDTH-1:0] a_lat_r;
   logic [WIDTH-1:0] b_lat_r;
   logic [WIDTH-1:0] p_lat_r;
   logic [WIDTH-1:0] acc_r;
   logic [CW-1:0]    cnt_r;

   logic             abort_s;
   logic             req_ok_s;
   logic [WIDTH+1:0] p_ext_s;
   logic [WIDTH+1:0] t_s;
   logic [WIDTH+1:0] t1_s;
   logic [WIDTH+1:0] t2_s;
   logic [WIDTH-1:0] r_next_s;

`ifdef MODMUL_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // Request is legal only for b < p and p >= 2, which keeps T below 3p every step.
   assign req_ok_s = (b < p) && (p > {{(WIDTH-1){1'b0}}, 1'b1});

   // One iteration: T = 2R + a[i]*b, then at most two conditional subtractions of p.
   always_comb begin
      p_ext_s = {2'b00, p_lat_r};
      if (a_lat_r[cnt_r]) begin
         t_s = {1'b0, acc_r, 1'b0} + {2'b00, b_lat_r};
      end else begin
         t_s = {1'b0, acc_r, 1'b0};
      end
      if (t_s >= p_ext_s) begin
         t1_s = t_s - p_ext_s;
      end else begin
         t1_s = t_s;
      end
      if (t1_s >= p_ext_s) begin
         t2_s = t1_s - p_ext_s;
      end else begin
         t2_s = t1_s;
      end
      r_next_s = t2_s[WIDTH-1:0];
   end

   // Control FSM, operand latches, accumulator and registered outputs.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_r <= ST_IDLE;
         a_lat_r <= {WIDTH{1'b0}};
         b_lat_r <= {WIDTH{1'b0}};
         p_lat_r <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         product <= {WIDTH{1'b0}};
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               busy <= 1'b0;
               if (start) begin
                  a_lat_r <= a;
                  b_lat_r <= b;
                  p_lat_r <= p;
                  if (req_ok_s) begin
                     acc_r   <= {WIDTH{1'b0}};
                     cnt_r   <= CNT_TOP;
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     state_r <= ST_RUN;
                  end else begin
                     err     <= 1'b1;
                     product <= {WIDTH{1'b0}};
                     done    <= 1'b1;
                     state_r <= ST_DONE;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (abort_s) begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  acc_r <= r_next_s;
                  if (cnt_r == CNT_ZERO) begin
                     product <= r_next_s;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state_r <= ST_DONE;
                  end else begin
                     cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Randomised self-checking bench for mod_mult_interleaved at WIDTH=8 and WIDTH=256.
module tb_mod_mult_interleaved;

   localparam logic [255:0] P256 =
      256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start8 = 1'b0;
   logic [7:0] a8 = 8'd0, b8 = 8'd0, p8 = 8'd0;
   logic       busy8, done8, err8;
   logic [7:0] prod8;

   logic         start256 = 1'b0;
   logic [255:0] a256 = '0, b256 = '0, p256 = '0;
   logic         busy256, done256, err256;
   logic [255:0] prod256;

   int checks = 0;
   int errors = 0;

   mod_mult_interleaved #(.WIDTH(8)) u_mm8 (
      .clk(clk), .Reset(rst), .start(start8), .a(a8), .b(b8), .p(p8),
      .busy(busy8), .done(done8), .err(err8), .product(prod8)
   );

   mod_mult_interleaved #(.WIDTH(256)) u_mm256 (
      .clk(clk), .Reset(rst), .start(start256), .a(a256), .b(b256), .p(p256),
      .busy(busy256), .done(done256), .err(err256), .product(prod256)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic req_valid(input logic [255:0] bi, input logic [255:0] pi);
      return (bi < pi) && (pi >= 256'd2);
   endfunction

   // Reference: plain modular arithmetic on double-width integers.
   function automatic logic [255:0] ref_mul(input logic [255:0] ai, bi, pi);
      logic [511:0] full;
      if (!req_valid(bi, pi)) return '0;
      full = {256'd0, ai} * {256'd0, bi};
      return 256'(full % {256'd0, pi});
   endfunction

   task automatic verify8(input string tag, input logic [7:0] ai, bi, pi);
      int lat;
      int nbusy;
      logic ok;
      ok = req_valid({248'd0, bi}, {248'd0, pi});
      @(negedge clk);
      a8 = ai; b8 = bi; p8 = pi; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; lat = 1; nbusy = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         if (busy8 === 1'b1) nbusy++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, ok ? 9 : 1);
      check({tag, "_busy"}, nbusy, ok ? 8 : 0);
      check({tag, "_prod"}, {248'd0, prod8}, ref_mul({248'd0, ai}, {248'd0, bi}, {248'd0, pi}));
      check({tag, "_err"}, {255'd0, err8}, {255'd0, !ok});
   endtask

   task automatic verify256(input string tag, input logic [255:0] ai, bi, pi);
      int lat;
      @(negedge clk);
      a256 = ai; b256 = bi; p256 = pi; start256 = 1'b1;
      @(negedge clk);
      start256 = 1'b0; lat = 1;
      while (done256 !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, 257);
      check({tag, "_prod"}, prod256, ref_mul(ai, bi, pi));
      check({tag, "_err"}, {255'd0, err256}, 256'd0);
   endtask

   initial begin
      int lat;
      int seen;
      logic [7:0] pa [3];
      logic [7:0] pb [3];
      logic [7:0] rp;
      logic [7:0] rb;
      logic [7:0] ra;
      logic [255:0] wa;
      logic [255:0] wb;

      // Reset state
      @(negedge clk);
      check("rst_busy", {255'd0, busy8}, 256'd0);
      check("rst_done", {255'd0, done8}, 256'd0);
      check("rst_err", {255'd0, err8}, 256'd0);
      check("rst_prod", {248'd0, prod8}, 256'd0);
      rst = 1'b0;

      verify8("basic", 8'd200, 8'd100, 8'd251);
      @(negedge clk);
      check("done_pulse_width", {255'd0, done8}, 256'd0);

      // Back-to-back issue in the DONE cycle
      pa[0] = 8'd250; pb[0] = 8'd250;
      pa[1] = 8'd0;   pb[1] = 8'd77;
      pa[2] = 8'd1;   pb[2] = 8'd250;
      @(negedge clk);
      a8 = pa[0]; b8 = pb[0]; p8 = 8'd251; start8 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start8 = 1'b0; lat = 1;
         while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         check("b2b_lat", lat, 9);
         check("b2b_prod", {248'd0, prod8}, ref_mul({248'd0, pa[k]}, {248'd0, pb[k]}, 256'd251));
         if (k < 2) begin
            a8 = pa[k+1]; b8 = pb[k+1]; start8 = 1'b1;
         end
      end

      // Rejected requests, then a valid one clears err
      verify8("rej_b_eq_p", 8'd5, 8'd251, 8'd251);
      verify8("rej_p_one", 8'd5, 8'd0, 8'd1);
      verify8("after_rej", 8'd3, 8'd5, 8'd7);

      // Randomised operands, every seventh one deliberately out of range
      for (int i = 0; i < 30; i++) begin
         rp = 8'($urandom_range(2, 255));
         ra = 8'($urandom_range(0, 255));
         if (i % 7 == 6) rb = 8'($urandom_range(int'(rp), 255));
         else            rb = 8'($urandom_range(0, int'(rp) - 1));
         verify8("rand8", ra, rb, rp);
      end

      // Operands change and start re-pulses mid-run
      @(negedge clk);
      a8 = 8'd123; b8 = 8'd45; p8 = 8'd233; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; lat = 1;
      while (done8 !== 1'b1 && lat < 40) begin
         if (lat == 4) begin
            a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom); start8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start8 = 1'b0;
      check("ignore_start_lat", lat, 9);
      check("ignore_start_prod", {248'd0, prod8}, ref_mul(256'd123, 256'd45, 256'd233));

      // P-256 field
      verify256("p256_two", 256'd2, P256 - 256'd1, P256);
      verify256("p256_ones", {256{1'b1}}, 256'd1, P256);
      for (int i = 0; i < 3; i++) begin
         wa = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         wb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         verify256("p256_rand", wa, wb % P256, P256);
      end

      // Asynchronous reset in the middle of RUN cycle 5
      @(negedge clk);
      a8 = 8'd77; b8 = 8'd66; p8 = 8'd239; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      for (int c = 1; c < 5; c++) @(negedge clk);
      check("pre_reset_busy", {255'd0, busy8}, 256'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", {255'd0, busy8}, 256'd0);
      check("async_rst_done", {255'd0, done8}, 256'd0);
      check("async_rst_err", {255'd0, err8}, 256'd0);
      check("async_rst_prod", {248'd0, prod8}, 256'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done8 === 1'b1 || busy8 === 1'b1) seen++;
      end
      check("no_done_after_reset", seen, 0);
      check("prod_after_reset", {248'd0, prod8}, 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_mult_interleaved.md
Name: mod_mult_interleaved

Overview:
- Parametrised radix-2 interleaved modular multiplier: product = (a * b) mod p for WIDTH-bit operands.
- Processes one bit of a per cycle, MSB first, with bounded reduction every step, so latency is fixed.
- Adds a start/busy/done handshake, operand latching and range checking.
- Serves as the field-multiply engine under the ECC point add/double controllers; WIDTH=256 for P-256-class curves.

Parameters:
- WIDTH, 256, operand, modulus and result width in bits; legal range 4..521.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising edge of clk in IDLE or DONE.
- a  input  WIDTH  multiplier operand; any value below 2^WIDTH.
- b  input  WIDTH  multiplicand; must be below p.
- p  input  WIDTH  modulus; must be at least 2.
- busy  output  1  high while a multiplication is in progress (RUN).
- done  output  1  one-cycle pulse; product and err are valid.
- err  output  1  set with done when the request was rejected; held until the next accepted start.
- product  output  WIDTH  registered result; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, err=0, product=0, accumulator R=0, counter=0. Asserting Reset mid-RUN abandons the operation; no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: on start, latch a, b, p into internal registers.
    - If b>=p or p<2: go to DONE with err=1 and product=0.
    - Otherwise: R=0, counter=WIDTH-1, err=0, go to RUN.
  - RUN: one iteration per cycle, using latched values only.
    - T = 2R + (a_lat[counter] ? b_lat : 0), computed at WIDTH+2 bits.
    - If T>=p, subtract p; if the result is still >=p, subtract p again.
    - R gets the result.
    - counter==0: load product=R_next, go to DONE. Otherwise decrement counter.
  - DONE: done=1 for exactly this cycle; busy=0.
    - Next state is IDLE, or RUN if start is asserted and the operands are valid (back-to-back issue).
    - An invalid back-to-back start goes back to DONE with err=1.
- Invariant: R<p after every iteration. Since b<p, T<3p, so two conditional subtractions suffice. Exceeding this bound is a design error.
- Latency: a start sampled at edge t0 gives done high in the cycle following edge t0+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Rejected request: done in the cycle following t0 (latency 1).
- start while busy is ignored. Inputs a, b and p may change freely after the start edge.
- Arithmetic is unsigned throughout. Comparators and subtractors are WIDTH+2 bits wide. Internal truncation happens only when loading R and product.
- start and Reset together: Reset wins.

Optional Feature:
- Macro MODMUL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high at a clock edge in RUN returns to IDLE.
  - No done pulse; product and err keep their previous values.
  - abort in IDLE or DONE has no effect; abort has priority over the final iteration.
  - Abort does not affect a start in the same cycle while in IDLE or DONE.
- Undefined: no abort port; every accepted RUN completes.

Test Plan:
1. WIDTH=8, p=251, a=200, b=100, pulse start -> busy for 8 cycles; done in cycle 9 after the start edge; product=171; err=0.
2. WIDTH=8, p=251, pairs (250,250), (0,77), (1,250) -> product 1, 0, 250; back-to-back starts issued in the DONE cycle give each result exactly 9 cycles apart.
3. WIDTH=8, p=251, b=251 (and separately p=1) -> done one cycle after start; err=1; product=0. The next valid start clears err.
4. WIDTH=256, p = P-256 prime, a=2, b=p-1 -> product=p-2 after 257 cycles. Also a=2^256-1, b=1 -> product=(2^256-1) mod p.
5. WIDTH=8, assert start, then change a/b/p mid-RUN and re-pulse start at cycle 4 -> result matches the originally latched operands; the second start is ignored.
6. Assert Reset asynchronously (mid-cycle) at RUN cycle 5 -> outputs are 0 immediately, state is IDLE, no done. With MODMUL_ABORT_EN defined, abort at cycle 5 gives no done and product holds its prior value.
